// File: rtl/mips_pkg.sv
// Constants and types shared by the MIPS fetch path and the CPU core.
// Instruction field encodings plus the fetch-unit state type.
package mips_pkg;

    localparam int unsigned INSTR_W       = 32;
    localparam logic [5:0]  OPCODE_RTYPE  = 6'h00;
    localparam logic [5:0]  FUNCT_SYSCALL = 6'h0C;
    localparam logic [5:0]  OPCODE_J      = 6'h02;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT,
        ERR
    } fetch_state_e;

    function automatic logic is_syscall(input logic [INSTR_W-1:0] instr);
        return (instr[31:26] == OPCODE_RTYPE) && (instr[5:0] == FUNCT_SYSCALL);
    endfunction

endpackage

// File: rtl/instr_mem_32.sv
// Instruction storage: synchronous write port, address-indexed read port.
// Contents are deliberately not reset so a loaded program survives reset.
module instr_mem_32
    import mips_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic                         clk_i,
    input  logic                         we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] waddr_i,
    input  logic [INSTR_W-1:0]           wdata_i,
    input  logic [$clog2(MEM_WORDS)-1:0] raddr_i,
    output logic [INSTR_W-1:0]           rdata_o
);

    logic [INSTR_W-1:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_32.sv
// Instruction fetch unit: PC, next-PC selection, loadable program memory and
// the IDLE/RUN/HALT/ERR control that feeds mips_cpu one instruction per cycle.
module instr_fetch_32
    import mips_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load_enable,
    input  logic [31:0]         load_addr,
    input  logic [INSTR_W-1:0]  load_data,
    input  logic                start,
    input  logic                stall,
    input  logic                jump,
    input  logic [25:0]         jump_target,
    input  logic                branch_taken,
    input  logic [15:0]         branch_offset,
    output logic [INSTR_W-1:0]  instruction,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    output logic                instr_valid,
    output logic                halted,
    output logic                err_invalid_address
);

    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam logic [29:0] DEPTH = 30'(MEM_WORDS);

    fetch_state_e       state_q;
    logic [31:0]        pc_q;
    logic [31:0]        pc_d;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    logic               halted_q;
    logic               err_q;

    logic [31:0]        pc_plus4_w;
    logic [31:0]        branch_disp;
    logic               addr_bad;
    logic               mem_we;
    logic [INSTR_W-1:0] mem_rdata;
    logic               unused_load_lsbs;

    assign pc_plus4_w       = pc_q + 32'd4;
    assign branch_disp      = {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign unused_load_lsbs = ^load_addr[1:0];

    // Outside RUN the only fetch that can happen is the start fetch at RESET_PC.
    always_comb begin
        pc_d = RESET_PC;
        if (state_q == RUN) begin
            if (jump) begin
                pc_d = {pc_plus4_w[31:28], jump_target, 2'b00};
            end else if (branch_taken) begin
                pc_d = pc_plus4_w + branch_disp;
            end else begin
                pc_d = pc_plus4_w;
            end
        end
        addr_bad = (pc_d[31:2] >= DEPTH) || (pc_d[1:0] != 2'b00);
        mem_we   = (state_q == IDLE) && load_enable && (load_addr[31:2] < DEPTH);
    end

    instr_mem_32 #(
        .MEM_WORDS (MEM_WORDS)
    ) u_mem (
        .clk_i   (clock),
        .we_i    (mem_we),
        .waddr_i (load_addr[AW+1:2]),
        .wdata_i (load_data),
        .raddr_i (pc_d[AW+1:2]),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!stall) begin
                        if (is_syscall(instr_q)) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                            valid_q  <= 1'b0;
                        end else begin
                            state_q <= addr_bad ? ERR : RUN;
                            pc_q    <= pc_d;
                            instr_q <= addr_bad ? '0 : mem_rdata;
                            valid_q <= !addr_bad;
                            err_q   <= addr_bad;
                        end
                    end
                end
                default: begin
                    // IDLE, HALT and ERR all restart identically on start.
                    if (start) begin
                        state_q  <= addr_bad ? ERR : RUN;
                        pc_q     <= pc_d;
                        instr_q  <= addr_bad ? '0 : mem_rdata;
                        valid_q  <= !addr_bad;
                        err_q    <= addr_bad;
                        halted_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign instruction         = instr_q;
    assign pc                  = pc_q;
    assign pc_plus4            = pc_plus4_w;
    assign instr_valid         = valid_q;
    assign halted              = halted_q;
    assign err_invalid_address = err_q;

endmodule

// File: tb/tb_instr_fetch_32.sv
// Directed bench for instr_fetch_32: a per-cycle vector table for the
// fetch/redirect/halt/error paths plus hand sequences for reset and loading.
module tb_instr_fetch_32;

    localparam logic [31:0] W0  = 32'h2001_0001;
    localparam logic [31:0] W1  = 32'h2002_0002;
    localparam logic [31:0] W2  = 32'h2003_0003;
    localparam logic [31:0] W3  = 32'h0000_000C;
    localparam logic [31:0] W16 = 32'h2010_0010;
    localparam logic [31:0] W17 = 32'h2011_0011;
    localparam logic [31:0] W63 = 32'h203F_003F;
    localparam logic [31:0] WN  = 32'h2004_0004;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_enable = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [25:0] jump_target = '0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = '0;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        halted;
    logic        err_invalid_address;

    int tests  = 0;
    int failed = 0;

    instr_fetch_32 #(
        .MEM_WORDS (64),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .load_enable         (load_enable),
        .load_addr           (load_addr),
        .load_data           (load_data),
        .start               (start),
        .stall               (stall),
        .jump                (jump),
        .jump_target         (jump_target),
        .branch_taken        (branch_taken),
        .branch_offset       (branch_offset),
        .instruction         (instruction),
        .pc                  (pc),
        .pc_plus4            (pc_plus4),
        .instr_valid         (instr_valid),
        .halted              (halted),
        .err_invalid_address (err_invalid_address)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        start;
        logic        stall;
        logic        jump;
        logic [25:0] jt;
        logic        br;
        logic [15:0] boff;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_halt;
        logic        e_err;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(input logic st, input logic sl, input logic j,
                                input logic [25:0] jt, input logic br, input logic [15:0] bo,
                                input logic [31:0] p, input logic [31:0] ins,
                                input logic v, input logic h, input logic e);
        vec_t r;
        r.start = st; r.stall = sl; r.jump = j; r.jt = jt; r.br = br; r.boff = bo;
        r.e_pc = p; r.e_instr = ins; r.e_valid = v; r.e_halt = h; r.e_err = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic e_v, input logic e_h, input logic e_e);
        chk({tag, " pc"}, pc, e_pc);
        chk({tag, " pc_plus4"}, pc_plus4, e_pc + 32'd4);
        chk({tag, " instruction"}, instruction, e_instr);
        chk({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, e_v});
        chk({tag, " halted"}, {31'd0, halted}, {31'd0, e_h});
        chk({tag, " err"}, {31'd0, err_invalid_address}, {31'd0, e_e});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
        load_enable = 1'b1;
        load_addr   = addr;
        load_data   = data;
        step();
        load_enable = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        //            st sl j  jt     br bo        pc       instr v  h  e
        vecs[0]  = mk(1, 0, 0, 26'h0,  0, 16'h0,    32'd0,   W0,  1, 0, 0);
        vecs[1]  = mk(0, 0, 0, 26'h0,  0, 16'h0,    32'd4,   W1,  1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 26'h0,  0, 16'h0,    32'd8,   W2,  1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 26'h0,  0, 16'h0,    32'd12,  W3,  1, 0, 0);
        vecs[4]  = mk(0, 0, 1, 26'h10, 0, 16'h0,    32'd12,  W3,  0, 1, 0);
        vecs[5]  = mk(0, 0, 0, 26'h0,  0, 16'h0,    32'd12,  W3,  0, 1, 0);
        vecs[6]  = mk(1, 0, 0, 26'h0,  0, 16'h0,    32'd0,   W0,  1, 0, 0);
        vecs[7]  = mk(0, 0, 0, 26'h0,  0, 16'h0,    32'd4,   W1,  1, 0, 0);
        vecs[8]  = mk(0, 0, 0, 26'h0,  0, 16'h0,    32'd8,   W2,  1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 26'h0,  1, 16'hFFFE, 32'd4,   W1,  1, 0, 0);
        vecs[10] = mk(0, 0, 0, 26'h0,  0, 16'h0,    32'd8,   W2,  1, 0, 0);
        vecs[11] = mk(0, 0, 1, 26'h10, 1, 16'hFFFE, 32'd64,  W16, 1, 0, 0);
        vecs[12] = mk(0, 0, 1, 26'h1,  0, 16'h0,    32'd4,   W1,  1, 0, 0);
        vecs[13] = mk(0, 1, 1, 26'h2,  0, 16'h0,    32'd4,   W1,  1, 0, 0);
        vecs[14] = mk(0, 1, 0, 26'h2,  0, 16'h0,    32'd4,   W1,  1, 0, 0);
        vecs[15] = mk(0, 1, 1, 26'h2,  1, 16'h0004, 32'd4,   W1,  1, 0, 0);
        vecs[16] = mk(0, 0, 1, 26'h10, 0, 16'h0,    32'd64,  W16, 1, 0, 0);
        vecs[17] = mk(0, 0, 1, 26'h40, 0, 16'h0,    32'd256, '0,  0, 0, 1);
        vecs[18] = mk(0, 0, 1, 26'h1,  0, 16'h0,    32'd256, '0,  0, 0, 1);
        vecs[19] = mk(1, 0, 0, 26'h0,  0, 16'h0,    32'd0,   W0,  1, 0, 0);
        vecs[20] = mk(0, 0, 1, 26'h3F, 0, 16'h0,    32'd252, W63, 1, 0, 0);
        vecs[21] = mk(0, 0, 0, 26'h0,  0, 16'h0,    32'd256, '0,  0, 0, 1);
        vecs[22] = mk(1, 0, 0, 26'h0,  0, 16'h0,    32'd0,   W0,  1, 0, 0);

        #2;
        check_all("reset", 32'd0, '0, 0, 0, 0);
        #10;
        reset = 1'b0;

        load_word(32'd0,   W0);
        load_word(32'd4,   W1);
        load_word(32'd8,   W2);
        load_word(32'd12,  W3);
        load_word(32'd64,  W16);
        load_word(32'd68,  W17);
        load_word(32'd252, W63);
        check_all("idle after load", 32'd0, '0, 0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            start         = vecs[i].start;
            stall         = vecs[i].stall;
            jump          = vecs[i].jump;
            jump_target   = vecs[i].jt;
            branch_taken  = vecs[i].br;
            branch_offset = vecs[i].boff;
            step();
            check_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                      vecs[i].e_valid, vecs[i].e_halt, vecs[i].e_err);
        end
        start = 0; stall = 0; jump = 0; branch_taken = 0;
        jump_target = '0; branch_offset = '0;

        // Asynchronous reset mid-RUN, then restart of the retained program.
        step();
        check_all("pre-reset", 32'd4, W1, 1, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        check_all("async reset", 32'd0, '0, 0, 0, 0);
        #2;
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("restart", 32'd0, W0, 1, 0, 0);

        // Load attempt during RUN must not alter memory.
        load_enable = 1'b1; load_addr = 32'd8; load_data = 32'hDEAD_BEEF;
        step();
        load_enable = 1'b0;
        check_all("load in run", 32'd4, W1, 1, 0, 0);
        reset_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check_all("word2 kept", 32'd8, W2, 1, 0, 0);

        // Simultaneous start and load: fetch returns the old word.
        reset_pulse();
        start = 1'b1; load_enable = 1'b1; load_addr = 32'd0; load_data = WN;
        step();
        start = 1'b0; load_enable = 1'b0;
        check_all("start+load", 32'd0, W0, 1, 0, 0);
        reset_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("new word0", 32'd0, WN, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
